// File: rtl/trackball_quad_enc.sv
// Emulated trackball encoder: N axes of signed motion deltas become paced quadrature
// (or direction + clock) pulse trains. Optional `TRAK_SCALE_EN adds a scale_i sensitivity shift.
`timescale 1ns/1ps
module trackball_quad_enc #(
   parameter int AXES     = 2,
   parameter int DW       = 8,
   parameter int ACC_W    = 12,
   parameter int STEP_DIV = 1
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic [AXES*DW-1:0]   delta_i,
   input  logic                 delta_vld_i,
   input  logic [AXES-1:0]      invert_i,
   input  logic                 mode_i,
`ifdef TRAK_SCALE_EN
   input  logic [1:0]           scale_i,
`endif
   output logic [AXES-1:0]      enc_a_o,
   output logic [AXES-1:0]      enc_b_o,
   output logic [AXES-1:0]      busy_o
);

   localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   // Delta after sign extension plus up to 3 bits of left shift.
   localparam int DXW = DW + 4;
   localparam int SW  = ((ACC_W > DXW) ? ACC_W : DXW) + 2;
   localparam logic signed [SW-1:0] ACC_MAX = SW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

   logic [PW-1:0] presc_reg;
   logic          tick;
   logic [1:0]    shift_amt;

`ifdef TRAK_SCALE_EN
   assign shift_amt = scale_i;
`else
   assign shift_amt = 2'd0;
`endif

   assign tick = (presc_reg == PW'(STEP_DIV - 1));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + PW'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < AXES; gi++) begin : g_axis
         logic signed [ACC_W-1:0] acc_reg, acc_next;
         logic [1:0]              phase_reg, phase_next;
         logic                    dir_reg, dir_next;
         logic                    clk_reg, clk_next;
         logic                    enc_a_reg, enc_b_reg, busy_reg;
         logic signed [DW:0]      d_ext;
         logic signed [SW-1:0]    d_scaled;
         logic signed [SW-1:0]    sum;
         logic                    step_pos, step_neg;
         logic [1:0]              gray_next;

         always_comb begin
            d_ext = {delta_i[gi*DW + DW - 1], delta_i[gi*DW +: DW]};
            if (invert_i[gi]) begin
               d_ext = -d_ext;
            end
            d_scaled = delta_vld_i ? (SW'(d_ext) <<< shift_amt) : '0;

            step_pos = tick && !acc_reg[ACC_W-1] && (acc_reg != '0);
            step_neg = tick && acc_reg[ACC_W-1];

            // Wide sum so the clamp sees the true value and never wraps.
            sum = SW'(acc_reg) + d_scaled;
            if (step_pos) begin
               sum = sum - SW'(1);
            end else if (step_neg) begin
               sum = sum + SW'(1);
            end

            if (sum > ACC_MAX) begin
               acc_next = ACC_MAX[ACC_W-1:0];
            end else if (sum < ACC_MIN) begin
               acc_next = ACC_MIN[ACC_W-1:0];
            end else begin
               acc_next = sum[ACC_W-1:0];
            end

            phase_next = phase_reg;
            dir_next   = dir_reg;
            clk_next   = clk_reg;
            if (step_pos) begin
               phase_next = phase_reg + 2'd1;
               dir_next   = 1'b1;
               clk_next   = ~clk_reg;
            end else if (step_neg) begin
               phase_next = phase_reg - 2'd1;
               dir_next   = 1'b0;
               clk_next   = ~clk_reg;
            end
            gray_next = {phase_next[1], phase_next[1] ^ phase_next[0]};
         end

         always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
               acc_reg   <= '0;
               phase_reg <= 2'd0;
               dir_reg   <= 1'b0;
               clk_reg   <= 1'b0;
               enc_a_reg <= 1'b0;
               enc_b_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end else begin
               acc_reg   <= acc_next;
               phase_reg <= phase_next;
               dir_reg   <= dir_next;
               clk_reg   <= clk_next;
               enc_a_reg <= mode_i ? dir_next : gray_next[1];
               enc_b_reg <= mode_i ? clk_next : gray_next[0];
               busy_reg  <= (acc_next != '0);
            end
         end

         assign enc_a_o[gi] = enc_a_reg;
         assign enc_b_o[gi] = enc_b_reg;
         assign busy_o[gi]  = busy_reg;
      end
   endgenerate

endmodule

// File: tb/tb_trackball_quad_enc.sv
// Randomised scoreboard bench for trackball_quad_enc: an integer motion model predicts the
// outputs every cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_trackball_quad_enc;

   localparam int AXES     = 2;
   localparam int DW       = 8;
   localparam int ACC_W    = 12;
   localparam int STEP_DIV = 4;
   localparam int ACC_MAX  = 2047;
   localparam int ACC_MIN  = -2048;

   logic                 clk_sys = 1'b0;
   logic                 reset_n = 1'b0;
   logic [AXES*DW-1:0]   delta_i = '0;
   logic                 delta_vld_i = 1'b0;
   logic [AXES-1:0]      invert_i = '0;
   logic                 mode_i = 1'b0;
   logic [1:0]           scale_i = 2'd0;
   logic [AXES-1:0]      enc_a_o, enc_b_o, busy_o;

   trackball_quad_enc #(
      .AXES(AXES), .DW(DW), .ACC_W(ACC_W), .STEP_DIV(STEP_DIV)
   ) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .delta_i     (delta_i),
      .delta_vld_i (delta_vld_i),
      .invert_i    (invert_i),
      .mode_i      (mode_i),
`ifdef TRAK_SCALE_EN
      .scale_i     (scale_i),
`endif
      .enc_a_o     (enc_a_o),
      .enc_b_o     (enc_b_o),
      .busy_o      (busy_o)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [AXES-1:0] a;
      logic [AXES-1:0] b;
      logic [AXES-1:0] busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   chg0 = 0, chg1 = 0;

   // Reference model: unbounded integer position, signed integer backlog, cycle counter.
   int   acc_m[AXES];
   int   pos_m[AXES];
   bit   dir_m[AXES];
   bit   clk_m[AXES];
   int   cyc_m = 0;
   int   gray_tab[4] = '{0, 1, 3, 2};

   task automatic model_step();
      exp_t e;
      logic signed [DW-1:0] raw;
      int d, st, g, sc;
      bit tick;
      e = '0;
      if (!reset_n) begin
         cyc_m = 0;
         for (int k = 0; k < AXES; k++) begin
            acc_m[k] = 0; pos_m[k] = 0; dir_m[k] = 0; clk_m[k] = 0;
         end
      end else begin
         tick  = ((cyc_m % STEP_DIV) == STEP_DIV - 1);
         cyc_m = cyc_m + 1;
`ifdef TRAK_SCALE_EN
         sc = int'(scale_i);
`else
         sc = 0;
`endif
         for (int k = 0; k < AXES; k++) begin
            raw = delta_i[k*DW +: DW];
            d = int'(raw);
            if (invert_i[k]) d = -d;
            d = d * (1 << sc);
            if (!delta_vld_i) d = 0;
            st = 0;
            if (tick) st = (acc_m[k] > 0) ? 1 : ((acc_m[k] < 0) ? -1 : 0);
            acc_m[k] = acc_m[k] + d - st;
            if (acc_m[k] > ACC_MAX) acc_m[k] = ACC_MAX;
            if (acc_m[k] < ACC_MIN) acc_m[k] = ACC_MIN;
            if (st != 0) begin
               pos_m[k] = pos_m[k] + st;
               dir_m[k] = (st > 0);
               clk_m[k] = ~clk_m[k];
            end
         end
      end
      for (int k = 0; k < AXES; k++) begin
         g = gray_tab[((pos_m[k] % 4) + 4) % 4];
         e.a[k]    = mode_i ? dir_m[k] : g[1];
         e.b[k]    = mode_i ? clk_m[k] : g[0];
         e.busy[k] = (acc_m[k] != 0);
      end
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk_sys);
         model_step();
      end
   end

   // Monitor: compares the registered outputs each cycle, and counts A/B changes per axis.
   initial begin
      exp_t e, act;
      logic [1:0] prev0, prev1;
      prev0 = 2'b00;
      prev1 = 2'b00;
      forever begin
         @(negedge clk_sys);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!reset_n) e = '0;
            act = {enc_a_o, enc_b_o, busy_o};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL out_cycle t=%0t actual a=%b b=%b busy=%b expected a=%b b=%b busy=%b",
                        $time, act.a, act.b, act.busy, e.a, e.b, e.busy);
            end
         end
         if ({enc_a_o[0], enc_b_o[0]} != prev0) chg0++;
         if ({enc_a_o[1], enc_b_o[1]} != prev1) chg1++;
         prev0 = {enc_a_o[0], enc_b_o[0]};
         prev1 = {enc_a_o[1], enc_b_o[1]};
      end
   end

   task automatic check_eq(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   task automatic strobe(input logic [AXES*DW-1:0] d, input logic [AXES-1:0] inv);
      @(posedge clk_sys); #1;
      delta_i = d; invert_i = inv; delta_vld_i = 1'b1;
      @(posedge clk_sys); #1;
      delta_vld_i = 1'b0; delta_i = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy_o != '0 && n < budget) begin
         @(posedge clk_sys); #1;
         n++;
      end
      n_checks++;
      if (busy_o != '0) begin
         n_fail++;
         $display("FAIL %s_timeout actual busy=%b expected busy=00 within %0d cycles", name, busy_o, budget);
      end
      idle(3);
   endtask

   initial begin
      int exp_drain;
      idle(3);
      n_checks++;
      if ({enc_a_o, enc_b_o, busy_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state actual=%b expected=0", {enc_a_o, enc_b_o, busy_o});
      end
      reset_n = 1'b1;

      // +3 on axis 0: three steps, axis 1 quiet
      chg0 = 0; chg1 = 0;
      strobe({8'd0, 8'd3}, 2'b00);
      wait_idle("t1", 200);
      check_eq("t1_steps_axis0", chg0, 3);
      check_eq("t1_static_axis1", chg1, 0);

      // -2 on axis 1, inverted then not
      chg1 = 0;
      strobe({8'hFE, 8'd0}, 2'b10);
      wait_idle("t2a", 200);
      check_eq("t2_inverted_steps", chg1, 2);
      chg1 = 0;
      strobe({8'hFE, 8'd0}, 2'b00);
      wait_idle("t2b", 200);
      check_eq("t2_plain_steps", chg1, 2);

      // most negative delta, inverted on axis 0 only
      chg0 = 0; chg1 = 0;
      strobe({8'h80, 8'h80}, 2'b01);
      wait_idle("minval", 2000);
      check_eq("minval_axis0", chg0, 128);
      check_eq("minval_axis1", chg1, 128);

      // saturation: 20 x +127 must clamp, then drain exactly the clamped backlog
      for (int i = 0; i < 20; i++) strobe({8'd0, 8'd127}, 2'b00);
      exp_drain = acc_m[0];
      chg0 = 0;
      wait_idle("sat", 12000);
      check_eq("sat_drain_steps", chg0, exp_drain);

      // dir+clk mode, then switch to quadrature mid-burst
      mode_i = 1'b1;
      strobe({8'd0, 8'hFD}, 2'b00);
      idle(5);
      mode_i = 1'b0;
      wait_idle("t5", 200);

      // async reset mid-drain
      strobe({8'd0, 8'd50}, 2'b00);
      idle(20);
      @(posedge clk_sys); #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_reset_outputs", int'({enc_a_o, enc_b_o, busy_o}), 0);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      chg0 = 0;
      idle(60);
      check_eq("no_steps_after_reset", chg0, 0);

`ifdef TRAK_SCALE_EN
      scale_i = 2'd2;
      chg0 = 0;
      strobe({8'd0, 8'd3}, 2'b00);
      wait_idle("scale", 400);
      check_eq("scale_x4_steps", chg0, 12);
      scale_i = 2'd0;
`endif

      // randomised traffic
      for (int i = 0; i < 500; i++) begin
         @(posedge clk_sys); #1;
         delta_vld_i = ($urandom_range(0, 5) == 0);
         delta_i     = (AXES*DW)'($urandom);
         invert_i    = AXES'($urandom);
         if ($urandom_range(0, 40) == 0) mode_i = ~mode_i;
`ifdef TRAK_SCALE_EN
         if ($urandom_range(0, 60) == 0) scale_i = 2'($urandom);
`endif
      end
      @(posedge clk_sys); #1;
      delta_vld_i = 1'b0;
      wait_idle("random", 40000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #(1_500_000);
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
